// File: rtl/serial_or_accumulator_pkg.sv
// Shared types and helpers for the serial OR accumulator.
package serial_or_accumulator_pkg;

   typedef enum logic {ST_COLLECT, ST_FULL} state_t;

   function automatic int count_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_or_accumulator_mux.sv
// 2:1 mux primitive used to build the OR stage and the running OR.
module serial_or_accumulator_mux (
   input  logic d0,
   input  logic d1,
   input  logic sel,
   output logic y
);

   assign y = sel ? d1 : d0;

endmodule

// File: rtl/serial_or_accumulator.sv
// Packs a serial bit stream LSB-first into words with a running OR,
// presented downstream through a one-word valid/ready buffer.
module serial_or_accumulator
   import serial_or_accumulator_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int CW    = count_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic             up_bit,
   input  logic             up_last,
   output logic             down_valid,
   input  logic             down_ready,
   output logic [WIDTH-1:0] down_data,
   output logic             down_any,
   output logic [CW-1:0]    down_count,
   output logic             down_partial
);

   state_t           state_r;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] collect_r;
   logic             acc_any_r;
   logic             down_valid_r;
   logic [WIDTH-1:0] down_data_r;
   logic             down_any_r;
   logic [CW-1:0]    down_count_r;
   logic             down_partial_r;

   logic             accept_s;
   logic             close_s;
   logic             any_next_s;
   logic [CW-1:0]    count_inc_s;
   logic [WIDTH-1:0] word_s;

   // While a word is held, a bit may only enter if the held word drains this cycle.
   assign up_ready    = (state_r == ST_COLLECT) ? 1'b1 : down_ready;
   assign accept_s    = up_valid & up_ready;
   assign count_inc_s = count_r + CW'(1);
   assign close_s     = accept_s & ((count_r == CW'(WIDTH - 1)) | up_last);
   assign word_s      = collect_r | ({{(WIDTH-1){1'b0}}, up_bit} << count_r);

   serial_or_accumulator_mux u_any_mux (
      .d0  (up_bit),
      .d1  (1'b1),
      .sel (acc_any_r),
      .y   (any_next_s)
   );

   // Collect state, word close into the output buffer, and downstream drain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= ST_COLLECT;
         count_r        <= '0;
         collect_r      <= '0;
         acc_any_r      <= 1'b0;
         down_valid_r   <= 1'b0;
         down_data_r    <= '0;
         down_any_r     <= 1'b0;
         down_count_r   <= '0;
         down_partial_r <= 1'b0;
      end else if (accept_s) begin
         // In ST_FULL the counters are already clear, so a refill starts a fresh word.
         if (close_s) begin
            down_data_r    <= word_s;
            down_count_r   <= count_inc_s;
            down_any_r     <= any_next_s;
            down_partial_r <= (count_inc_s < CW'(WIDTH));
            down_valid_r   <= 1'b1;
            state_r        <= ST_FULL;
            count_r        <= '0;
            collect_r      <= '0;
            acc_any_r      <= 1'b0;
         end else begin
            collect_r      <= word_s;
            count_r        <= count_inc_s;
            acc_any_r      <= any_next_s;
            down_valid_r   <= 1'b0;
            state_r        <= ST_COLLECT;
         end
      end else if ((state_r == ST_FULL) && down_ready) begin
         down_valid_r <= 1'b0;
         state_r      <= ST_COLLECT;
      end
   end

   assign down_valid   = down_valid_r;
   assign down_data    = down_data_r;
   assign down_any     = down_any_r;
   assign down_count   = down_count_r;
   assign down_partial = down_partial_r;

endmodule

// File: tb/tb_serial_or_accumulator.sv
// Randomized and directed bench for serial_or_accumulator against a queue-based word model.
module tb_serial_or_accumulator;

   localparam int WIDTH = 8;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk        = 1'b0;
   logic             rst        = 1'b1;
   logic             up_valid   = 1'b0;
   logic             up_bit     = 1'b0;
   logic             up_last    = 1'b0;
   logic             down_ready = 1'b0;
   logic             up_ready;
   logic             down_valid;
   logic [WIDTH-1:0] down_data;
   logic             down_any;
   logic [CW-1:0]    down_count;
   logic             down_partial;

   serial_or_accumulator #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .up_valid     (up_valid),
      .up_ready     (up_ready),
      .up_bit       (up_bit),
      .up_last      (up_last),
      .down_valid   (down_valid),
      .down_ready   (down_ready),
      .down_data    (down_data),
      .down_any     (down_any),
      .down_count   (down_count),
      .down_partial (down_partial)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: pending bits of the open word plus the held output word.
   bit               m_q[$];
   bit               m_hold;
   logic [WIDTH-1:0] m_data;
   int               m_count;
   bit               m_any;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_hold  = 1'b0;
      m_data  = '0;
      m_count = 0;
      m_any   = 1'b0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_valid"},   {31'd0, down_valid},   32'd0);
      chk({tag, "_data"},    {24'd0, down_data},    32'd0);
      chk({tag, "_any"},     {31'd0, down_any},     32'd0);
      chk({tag, "_count"},   {28'd0, down_count},   32'd0);
      chk({tag, "_partial"}, {31'd0, down_partial}, 32'd0);
      chk({tag, "_ready"},   {31'd0, up_ready},     32'd1);
   endtask

   task automatic check_out();
      chk("down_valid", {31'd0, down_valid}, {31'd0, m_hold});
      if (m_hold) begin
         chk("down_data",    {24'd0, down_data},    {24'd0, m_data});
         chk("down_count",   {28'd0, down_count},   m_count);
         chk("down_any",     {31'd0, down_any},     {31'd0, m_any});
         chk("down_partial", {31'd0, down_partial}, (m_count < WIDTH) ? 32'd1 : 32'd0);
      end
   endtask

   task automatic cycle(input bit v, input bit b, input bit l, input bit dr);
      bit exp_ready;
      bit acc;
      @(negedge clk);
      up_valid   = v;
      up_bit     = b;
      up_last    = l;
      down_ready = dr;
      #1;
      exp_ready = !m_hold || dr;
      chk("up_ready", {31'd0, up_ready}, {31'd0, exp_ready});
      acc = v && exp_ready;
      @(posedge clk);
      #1;
      if (m_hold && dr) m_hold = 1'b0;
      if (acc) begin
         m_q.push_back(b);
         if (m_q.size() == WIDTH || l) begin
            m_data  = '0;
            m_any   = 1'b0;
            m_count = m_q.size();
            for (int i = 0; i < m_q.size(); i++) begin
               m_data[i] = m_q[i];
               m_any     = m_any | m_q[i];
            end
            m_q.delete();
            m_hold = 1'b1;
         end
      end
      check_out();
   endtask

   initial begin
      bit t1_bits[8];
      bit t5_bits[3];
      t1_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      t5_bits = '{1'b1, 1'b0, 1'b1};
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      @(negedge clk);
      rst = 1'b0;

      // 1: full word 0x0D
      for (int i = 0; i < 8; i++) cycle(1'b1, t1_bits[i], 1'b0, 1'b1);
      chk("t1_data",    {24'd0, down_data},    32'h0D);
      chk("t1_count",   {28'd0, down_count},   32'd8);
      chk("t1_partial", {31'd0, down_partial}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 2: all-zero word
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t2_any", {31'd0, down_any}, 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 3: early close after three bits
      cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t3_data",    {24'd0, down_data},    32'h06);
      chk("t3_partial", {31'd0, down_partial}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 4: backpressure hold, then drain and refill in one cycle
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'(i % 2), 1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t4_bit0", {31'd0, down_data[0]}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 5: back-to-back single-bit words
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, t5_bits[i], 1'b1, 1'b1);
         chk("t5_count", {28'd0, down_count}, 32'd1);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b1);

      // 6: reset mid-word discards the pending bits
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      up_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check_zero_outputs("t6_rst");
      #2;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      chk("t6_data", {24'd0, down_data}, 32'h00);
      chk("t6_any",  {31'd0, down_any},  32'd0);

      // Random traffic with occasional early closes and backpressure
      for (int i = 0; i < 600; i++) begin
         cycle(1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 5) == 0),
               1'($urandom_range(0, 9) < 7));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
